score_display: RTL and testbench
================================

# score_display

Drives the four-digit, active-low, multiplexed seven-segment display with both players' scores. The two 5-bit score values produced by the per-player score counters are converted from binary to two-digit BCD by a sequential double-dabble engine. The digits are then time-multiplexed onto a shared segment bus. This block sits between the two score counters and the board display pins.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit stays lit (1 ms at 100 MHz); must be ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- score_p1  input  5  player 1 score, binary 0..31.
- score_p2  input  5  player 2 score, binary 0..31.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anodes, active-low, one-hot-low, registered. an[3] = p1 tens, an[2] = p1 ones, an[1] = p2 tens, an[0] = p2 ones.
- dp  output  1  decimal point, active-low, registered.
- busy  output  1  high while a conversion is in flight.

## Operation
- **Snapshot registers.** snap_p1 and snap_p2 are 5 bits each and reset to 0. They hold the last scores accepted for conversion.
- **Conversion FSM** has three states: IDLE, SHIFT, COMMIT.
  - IDLE: if {score_p1, score_p2} != {snap_p1, snap_p2}, then:
    - load both snapshots;
    - load both shift registers: 8-bit BCD field = 0, 5-bit binary field = the input;
    - clear the shift count;
    - go to SHIFT.
  - If the inputs equal the snapshots, stay in IDLE.
  - SHIFT: each cycle, per player:
    - add 3 to the ones nibble if it is ≥ 5 (same rule for the tens nibble);
    - then shift the whole register left by 1.
    - After the 5th shift, go to COMMIT.
  - COMMIT: copy both BCD fields to the display registers bcd_p1 and bcd_p2 in the same edge, so the update is atomic. Return to IDLE.
- **Input changes during SHIFT/COMMIT** are ignored. On return to IDLE the snapshot mismatch starts a fresh conversion. The final displayed value always matches the last stable input.
- **Tens range.** The tens digit is 0..3, since 31 maps to tens 3, ones 1.
- **Scan.** The refresh counter runs 0..REFRESH_DIV−1 and wraps. When it wraps, the digit index advances 0→1→2→3→0. In that same edge an, seg and dp are loaded for the new index:
  - an: index 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
  - seg shows the selected digit from bcd_p1/bcd_p2.
- **dp** is driven low only when index = 2 (separator after p1 ones); it is high for all other indices.
- **Segment codes** (gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Reset**, asynchronous, any state including mid-conversion:
  - FSM = IDLE, snapshots = 0, bcd registers = 0, refresh counter = 0, index = 0;
  - an = 1110, seg = 1000000, dp = 1, busy = 0;
  - no conversion starts after reset unless the inputs are nonzero.

## Timing
- **Latency.** If the inputs differ at IDLE edge E0:
  - shifts occur at E1..E5;
  - COMMIT writes bcd at E6;
  - the new digits appear on seg at the next scan edge that selects each digit.
- **busy** is high from E1 through E6, i.e. 6 cycles in the SHIFT and COMMIT states. It is low in IDLE.
- **Back-to-back.** A change arriving during busy starts its conversion at the IDLE edge following E6, so the worst case is 13 cycles to commit.
- **Scan timing.**
  - Each digit is held for exactly REFRESH_DIV cycles; the full frame is 4·REFRESH_DIV.
  - The refresh counter width is ceil(log2(REFRESH_DIV)).
  - The scan is never stalled by conversion.

## Configuration
- SCORE_DISPLAY_BLANK_EN
  - Defined: a tens digit equal to 0 drives seg = 1111111 (blank) while its anode is still asserted. Ones digits are never blanked.
  - Undefined: tens digit 0 shows 1000000. Reset seg is unchanged, because index 0 is a ones digit.

## Test plan
- Reset low for 3 cycles, then release with inputs 0 → an = 1110, seg = 1000000, dp = 1, busy = 0; busy stays 0.
- REFRESH_DIV = 4; score_p1 = 31, score_p2 = 7 → busy high for 6 cycles. The scan then shows:
  - an 1110: seg 1111000 (7);
  - an 1101: seg 1000000 (0);
  - an 1011: seg 1111001 (1), dp = 0;
  - an 0111: seg 0110000 (3).
- score_p1 5 → 12 at the 2nd cycle of busy → bcd_p1 commits 0x05, then busy re-asserts and bcd_p1 commits 0x12. Total busy = 12 cycles, with ≥1 IDLE cycle between the two conversions.
- Boundaries: sweep p2 through 9 → 10 → 0 → 31 → digits 0,9 / 1,0 / 0,0 / 3,1, each correct after commit.
- Assert reset at the 3rd shift of a conversion → all outputs at reset values immediately. After release with the same inputs held, a full conversion reruns and commits the correct value.
- With SCORE_DISPLAY_BLANK_EN, p2 = 7 → at an = 1101, seg = 1111111. Without the macro → seg = 1000000.

Source files
------------

// File: rtl/score_display.sv
// score_display: converts two 5-bit player scores to BCD with a sequential
// double-dabble engine, then time-multiplexes four active-low digits.
// Optional feature: define SCORE_DISPLAY_BLANK_EN to blank a tens digit of 0.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] score_p1,
    input  logic [4:0] score_p2,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_cnt;
    logic [7:0]       r_bcd_p1;
    logic [7:0]       r_bcd_p2;
    logic [1:0][4:0]  w_score;
    logic [1:0]       w_snap_eq;
    logic [1:0][7:0]  w_bcd;
    logic             w_change;
    logic             w_load;
    logic             w_last_shift;

    assign w_score[0]   = score_p1;
    assign w_score[1]   = score_p2;
    assign w_change     = ~(&w_snap_eq);
    assign w_load       = (r_state == S_IDLE) && w_change;
    assign w_last_shift = (r_cnt == 3'd4);
    assign busy         = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state: start on snapshot mismatch, five shifts, one commit cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_change) w_state_next = S_SHIFT;
            S_SHIFT:  if (w_last_shift) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Shift counter: cleared on load, counts completed shifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   r_cnt <= 3'd0;
        else if (w_load)              r_cnt <= 3'd0;
        else if (r_state == S_SHIFT)  r_cnt <= r_cnt + 3'd1;
    end

    // Per-player snapshot and double-dabble register {tens, ones, binary}
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            logic [4:0]  r_snap;
            logic [12:0] r_sh;
            logic [12:0] w_adj;

            assign w_adj[12:9] = (r_sh[12:9] >= 4'd5) ? r_sh[12:9] + 4'd3 : r_sh[12:9];
            assign w_adj[8:5]  = (r_sh[8:5]  >= 4'd5) ? r_sh[8:5]  + 4'd3 : r_sh[8:5];
            assign w_adj[4:0]  = r_sh[4:0];
            assign w_snap_eq[gi] = (r_snap == w_score[gi]);
            assign w_bcd[gi]     = r_sh[12:5];

            // Load on a new score, otherwise adjust-then-shift while converting
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_snap <= 5'd0;
                    r_sh   <= 13'd0;
                end else if (w_load) begin
                    r_snap <= w_score[gi];
                    r_sh   <= {8'd0, w_score[gi]};
                end else if (r_state == S_SHIFT) begin
                    r_sh   <= w_adj << 1;
                end
            end
        end
    endgenerate

    // Both players' digits update on the same edge so the display never tears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd_p1 <= 8'd0;
            r_bcd_p2 <= 8'd0;
        end else if (r_state == S_COMMIT) begin
            r_bcd_p1 <= w_bcd[0];
            r_bcd_p2 <= w_bcd[1];
        end
    end

    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_next;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;
    logic          w_dp_next;

    assign w_idx_next = r_idx + 2'd1;

    // Digit select, segment decode and anode/dp for the upcoming index
    always_comb begin
        w_digit = 4'd0;
        case (w_idx_next)
            2'd0:    w_digit = r_bcd_p2[3:0];
            2'd1:    w_digit = r_bcd_p2[7:4];
            2'd2:    w_digit = r_bcd_p1[3:0];
            default: w_digit = r_bcd_p1[7:4];
        endcase
        w_seg_next = 7'b1111111;
        case (w_digit)
            4'd0:    w_seg_next = 7'b1000000;
            4'd1:    w_seg_next = 7'b1111001;
            4'd2:    w_seg_next = 7'b0100100;
            4'd3:    w_seg_next = 7'b0110000;
            4'd4:    w_seg_next = 7'b0011001;
            4'd5:    w_seg_next = 7'b0010010;
            4'd6:    w_seg_next = 7'b0000010;
            4'd7:    w_seg_next = 7'b1111000;
            4'd8:    w_seg_next = 7'b0000000;
            4'd9:    w_seg_next = 7'b0010000;
            default: w_seg_next = 7'b1111111;
        endcase
`ifdef SCORE_DISPLAY_BLANK_EN
        // Odd indices are tens digits; a leading zero is blanked
        if (w_idx_next[0] && (w_digit == 4'd0)) w_seg_next = 7'b1111111;
`else
`endif
        w_an_next             = 4'b1111;
        w_an_next[w_idx_next] = 1'b0;
        w_dp_next             = (w_idx_next != 2'd2);
    end

    // Free-running scan: advance digit and load outputs when the counter wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            an        <= 4'b1110;
            seg       <= 7'b1000000;
            dp        <= 1'b1;
        end else if (r_refresh == REF_MAX) begin
            r_refresh <= '0;
            r_idx     <= w_idx_next;
            an        <= w_an_next;
            seg       <= w_seg_next;
            dp        <= w_dp_next;
        end else begin
            r_refresh <= r_refresh + CW'(1);
        end
    end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;
    localparam int RD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] p1    = 5'd0;
    logic [4:0] p2    = 5'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    score_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(rst_n), .score_p1(p1), .score_p2(p2),
        .seg(seg), .an(an), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef SCORE_DISPLAY_BLANK_EN
    localparam logic [6:0] TENS0 = 7'b1111111;
`else
    localparam logic [6:0] TENS0 = 7'b1000000;
`endif

    logic [6:0] seg_tab [10];
    logic [3:0] an_tab  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected segments for a scan index given displayed decimal scores
    function automatic logic [6:0] exp_seg(input int idx, input int d1, input int d2);
        int v;
        v = (idx == 0) ? d2 % 10 : (idx == 1) ? d2 / 10 : (idx == 2) ? d1 % 10 : d1 / 10;
        exp_seg = seg_tab[v];
`ifdef SCORE_DISPLAY_BLANK_EN
        if ((idx % 2 == 1) && v == 0) exp_seg = 7'b1111111;
`endif
    endfunction

    // Behavioural model: conversions take 6 busy cycles and publish the sampled scores
    int m_ref, m_idx, m_left, m_snap1, m_snap2, m_disp1, m_disp2;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp, m_busy;

    task automatic model_reset();
        m_ref = 0; m_idx = 0; m_left = 0;
        m_snap1 = 0; m_snap2 = 0; m_disp1 = 0; m_disp2 = 0;
        m_an = 4'b1110; m_seg = 7'b1000000; m_dp = 1'b1; m_busy = 1'b0;
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (m_ref == RD - 1) begin
                    m_ref = 0;
                    m_idx = (m_idx + 1) % 4;
                    m_an  = an_tab[m_idx];
                    m_seg = exp_seg(m_idx, m_disp1, m_disp2);
                    m_dp  = (m_idx == 2) ? 1'b0 : 1'b1;
                end else begin
                    m_ref++;
                end
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_disp1 = m_snap1;
                        m_disp2 = m_snap2;
                    end
                end else if (int'(p1) != m_snap1 || int'(p2) != m_snap2) begin
                    m_snap1 = int'(p1);
                    m_snap2 = int'(p2);
                    m_left  = 6;
                end
                m_busy = (m_left > 0);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("an",   {28'd0, an},   {28'd0, m_an});
            check("seg",  {25'd0, seg},  {25'd0, m_seg});
            check("dp",   {31'd0, dp},   {31'd0, m_dp});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
        end
    end

    task automatic count_busy(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy) c++;
        end
    endtask

    task automatic expect_digit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
        int k;
        k = 0;
        while (an !== a && k < 24) begin
            @(negedge clk);
            k++;
        end
        if (an !== a) begin
            check({name, "_timeout"}, {28'd0, an}, {28'd0, a});
        end else begin
            check({name, "_seg"}, {25'd0, seg}, {25'd0, s});
            check({name, "_dp"},  {31'd0, dp},  {31'd0, d});
        end
    endtask

    logic [4:0] sweep_v    [4];
    logic [6:0] sweep_ones [4];
    logic [6:0] sweep_tens [4];

    initial begin
        int c, rises, falls;
        logic prev;
        sweep_v[0] = 5'd9;  sweep_ones[0] = 7'b0010000; sweep_tens[0] = TENS0;
        sweep_v[1] = 5'd10; sweep_ones[1] = 7'b1000000; sweep_tens[1] = 7'b1111001;
        sweep_v[2] = 5'd0;  sweep_ones[2] = 7'b1000000; sweep_tens[2] = TENS0;
        sweep_v[3] = 5'd31; sweep_ones[3] = 7'b1111001; sweep_tens[3] = 7'b0110000;

        // Reset with zero inputs
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_an",   {28'd0, an},   32'hE);
        check("rst_seg",  {25'd0, seg},  32'h40);
        check("rst_dp",   {31'd0, dp},   32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        count_busy(12, c);
        check("idle_busy_cycles", c, 0);

        // 31 / 7
        @(negedge clk);
        p1 = 5'd31; p2 = 5'd7;
        count_busy(20, c);
        check("busy_31_7", c, 6);
        repeat (16) @(negedge clk);
        expect_digit("p2_ones_7",  4'b1110, 7'b1111000, 1'b1);
        expect_digit("p2_tens_0",  4'b1101, TENS0,      1'b1);
        expect_digit("p1_ones_1",  4'b1011, 7'b1111001, 1'b0);
        expect_digit("p1_tens_3",  4'b0111, 7'b0110000, 1'b1);

        // Change during busy: 5 then 12
        @(negedge clk);
        p1 = 5'd5;
        @(negedge clk);
        @(negedge clk);
        check("busy_2nd_cycle", {31'd0, busy}, 32'd1);
        p1 = 5'd12;
        c = 2; rises = 0; falls = 0; prev = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) c++;
            if (!prev && busy) rises++;
            if (prev && !busy) begin
                falls++;
                if (falls == 1) check("bcd_p1_first", {24'd0, dut.r_bcd_p1}, 32'h05);
            end
            prev = busy;
        end
        check("busy_total_b2b", c, 12);
        check("busy_rises_b2b", rises, 1);
        check("busy_falls_b2b", falls, 2);
        check("bcd_p1_second", {24'd0, dut.r_bcd_p1}, 32'h12);

        // p2 boundary sweep
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p2 = sweep_v[i];
            repeat (30) @(negedge clk);
            expect_digit($sformatf("sweep%0d_ones", sweep_v[i]), 4'b1110, sweep_ones[i], 1'b1);
            expect_digit($sformatf("sweep%0d_tens", sweep_v[i]), 4'b1101, sweep_tens[i], 1'b1);
        end

        // Reset during the third shift
        @(negedge clk);
        p1 = 5'd20; p2 = 5'd3;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an",   {28'd0, an},   32'hE);
        check("midrst_seg",  {25'd0, seg},  32'h40);
        check("midrst_dp",   {31'd0, dp},   32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(20, c);
        check("busy_rerun", c, 6);
        repeat (16) @(negedge clk);
        expect_digit("rerun_p2_ones", 4'b1110, 7'b0110000, 1'b1);
        expect_digit("rerun_p2_tens", 4'b1101, TENS0,      1'b1);
        expect_digit("rerun_p1_ones", 4'b1011, 7'b1000000, 1'b0);
        expect_digit("rerun_p1_tens", 4'b0111, 7'b0100100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
